// File: rtl/jts16_scroll_mmr.sv
// jts16_scroll_mmr: System 16 tilemap scroll register file, CPU MMR window 0xE00-0xFFF.
// Macro JTS16_SCROLL_LATCH_EN enables shadow/active double buffering committed at vblank.
module jts16_scroll_mmr #(
    parameter int LAYERS = 2,
    parameter int MODEL  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flip,
    input  logic                  vblank,
    input  logic                  char_cs,
    input  logic [11:1]           cpu_addr,
    input  logic [15:0]           cpu_dout,
    input  logic [1:0]            dsn,
    output logic [16*LAYERS-1:0]  pages,
    output logic [16*LAYERS-1:0]  hpos,
    output logic [16*LAYERS-1:0]  vpos,
    output logic [LAYERS-1:0]     rowscr_en,
    output logic [LAYERS-1:0]     colscr_en,
    output logic                  dirty,
    input  logic [7:0]            st_addr,
    output logic [7:0]            st_dout
);

    // Register file index = {type, layer}; four slots per type
    localparam int NREG = 32;
    localparam logic [2:0] T_PG = 3'd0;
    localparam logic [2:0] T_PF = 3'd1;
    localparam logic [2:0] T_VP = 3'd2;
    localparam logic [2:0] T_HP = 3'd3;
    localparam logic [2:0] T_AP = 3'd4;
    localparam logic [2:0] T_AV = 3'd5;
    localparam logic [2:0] T_AH = 3'd6;
    localparam int I_PG = 0;
    localparam int I_PF = 4;
    localparam int I_VP = 8;
    localparam int I_HP = 12;
    localparam int I_AP = 16;
    localparam int I_AV = 20;
    localparam int I_AH = 24;

    logic        wr;
    logic [8:0]  off;
    logic        map_hit;
    logic [2:0]  tsel;
    logic [1:0]  ksel;
    logic        hit;
    logic [4:0]  widx;
    logic        commit;

    logic [15:0] act_q [NREG];
    logic [15:0] act_d [NREG];
`ifdef JTS16_SCROLL_LATCH_EN
    logic [15:0] sh_q [NREG];
    logic [15:0] sh_d [NREG];
`endif
    logic        vb_q;
    logic        dirty_q, dirty_d;
    logic [6:0]  cnt_q, cnt_d;
    logic [16*LAYERS-1:0] pages_q, pages_d;
    logic [16*LAYERS-1:0] hpos_q, hpos_d;
    logic [16*LAYERS-1:0] vpos_q, vpos_d;
    logic [LAYERS-1:0]    row_q, row_d;
    logic [LAYERS-1:0]    col_q, col_d;
    logic [7:0]  st_q, st_d;

    function automatic logic [15:0] merge(input logic [15:0] old,
                                          input logic [15:0] din,
                                          input logic [1:0]  ds);
        logic [15:0] r;
        r = old;
        if (!ds[1]) r[15:8] = din[15:8];
        if (!ds[0]) r[7:0]  = din[7:0];
        return r;
    endfunction

    // Status slot n of layer k: pages, vpos, hpos (main or alt set)
    function automatic int sidx(input int n, input int k, input bit alt);
        int b;
        case (n / 2)
            0:       b = alt ? I_AP : I_PG;
            1:       b = alt ? I_AV : I_VP;
            default: b = alt ? I_AH : I_HP;
        endcase
        return b + k;
    endfunction

    function automatic logic [7:0] pick(input logic [15:0] v, input int n);
        return (n % 2 == 1) ? v[15:8] : v[7:0];
    endfunction

    assign wr     = char_cs && (cpu_addr[11:9] == 3'b111) && (dsn != 2'b11);
    assign off    = {cpu_addr[8:1], 1'b0};
    assign commit = vblank && !vb_q;

    // Address decode of the MMR window into register type and layer
    always_comb begin
        map_hit = 1'b0;
        tsel    = T_PG;
        ksel    = 2'd0;
        if (MODEL == 0) begin
            case (off)
                9'h08E: begin map_hit = 1'b1; tsel = T_PF; ksel = 2'd0; end
                9'h09E: begin map_hit = 1'b1; tsel = T_PG; ksel = 2'd0; end
                9'h08C: begin map_hit = 1'b1; tsel = T_PF; ksel = 2'd1; end
                9'h09C: begin map_hit = 1'b1; tsel = T_PG; ksel = 2'd1; end
                9'h124: begin map_hit = 1'b1; tsel = T_VP; ksel = 2'd0; end
                9'h126: begin map_hit = 1'b1; tsel = T_VP; ksel = 2'd1; end
                9'h1F8: begin map_hit = 1'b1; tsel = T_HP; ksel = 2'd0; end
                9'h1FA: begin map_hit = 1'b1; tsel = T_HP; ksel = 2'd1; end
                default: ;
            endcase
        end else if (MODEL == 1) begin
            for (int k = 0; k < 2; k++) begin
                if (off == 9'(9'h080 + 2*k)) begin map_hit = 1'b1; tsel = T_PG; ksel = 2'(k); end
                if (off == 9'(9'h084 + 2*k)) begin map_hit = 1'b1; tsel = T_AP; ksel = 2'(k); end
                if (off == 9'(9'h090 + 2*k)) begin map_hit = 1'b1; tsel = T_VP; ksel = 2'(k); end
                if (off == 9'(9'h094 + 2*k)) begin map_hit = 1'b1; tsel = T_AV; ksel = 2'(k); end
                if (off == 9'(9'h098 + 2*k)) begin map_hit = 1'b1; tsel = T_HP; ksel = 2'(k); end
                if (off == 9'(9'h09C + 2*k)) begin map_hit = 1'b1; tsel = T_AH; ksel = 2'(k); end
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (off == 9'(9'h0A0 + 2*k)) begin map_hit = 1'b1; tsel = T_PG; ksel = 2'(k); end
                if (off == 9'(9'h0A8 + 2*k)) begin map_hit = 1'b1; tsel = T_VP; ksel = 2'(k); end
                if (off == 9'(9'h0B0 + 2*k)) begin map_hit = 1'b1; tsel = T_HP; ksel = 2'(k); end
            end
        end
        hit  = wr && map_hit && (int'(ksel) < LAYERS);
        widx = {tsel, ksel};
    end

`ifdef JTS16_SCROLL_LATCH_EN
    // Writes land in shadow; vblank edge copies shadow (incl. same-cycle write) to active
    always_comb begin
        sh_d    = sh_q;
        act_d   = act_q;
        dirty_d = dirty_q;
        if (hit) begin
            sh_d[widx] = merge(sh_q[widx], cpu_dout, dsn);
            dirty_d    = 1'b1;
        end
        if (commit) begin
            act_d   = sh_d;
            dirty_d = 1'b0;
        end
    end
`else
    // Single register set: writes go straight to active
    always_comb begin
        act_d   = act_q;
        dirty_d = 1'b0;
        if (hit) act_d[widx] = merge(act_q[widx], cpu_dout, dsn);
    end
`endif

    // Commit counter advances on every vblank rising edge
    always_comb begin
        cnt_d = commit ? cnt_q + 7'd1 : cnt_q;
    end

    // Renderer-facing outputs derived from the active set
    always_comb begin
        pages_d = '0;
        hpos_d  = '0;
        vpos_d  = '0;
        row_d   = '0;
        col_d   = '0;
        for (int k = 0; k < LAYERS; k++) begin
            if (MODEL == 0)
                pages_d[16*k +: 16] = flip ? act_q[I_PF+k] : act_q[I_PG+k];
            else
                pages_d[16*k +: 16] = act_q[I_PG+k];
            vpos_d[16*k +: 16] = act_q[I_VP+k];
            hpos_d[16*k +: 16] = act_q[I_HP+k];
            row_d[k] = (MODEL != 0) && act_q[I_HP+k][15];
            col_d[k] = (MODEL == 2) && act_q[I_VP+k][15];
        end
    end

    // Status dump byte select
    always_comb begin
        st_d = 8'h00;
        for (int k = 0; k < LAYERS; k++) begin
            for (int n = 0; n < 6; n++) begin
                if (st_addr == 8'(6*k + n))
                    st_d = pick(act_q[sidx(n, k, 1'b0)], n);
                if (MODEL == 1 && st_addr == 8'(64 + 6*k + n))
                    st_d = pick(act_q[sidx(n, k, 1'b1)], n);
            end
        end
        if (st_addr == 8'hFF) st_d = {dirty_q, cnt_q};
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_q   <= '{default: '0};
`ifdef JTS16_SCROLL_LATCH_EN
            sh_q    <= '{default: '0};
`endif
            vb_q    <= 1'b0;
            dirty_q <= 1'b0;
            cnt_q   <= '0;
            pages_q <= '0;
            hpos_q  <= '0;
            vpos_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            st_q    <= '0;
        end else begin
            act_q   <= act_d;
`ifdef JTS16_SCROLL_LATCH_EN
            sh_q    <= sh_d;
`endif
            vb_q    <= vblank;
            dirty_q <= dirty_d;
            cnt_q   <= cnt_d;
            pages_q <= pages_d;
            hpos_q  <= hpos_d;
            vpos_q  <= vpos_d;
            row_q   <= row_d;
            col_q   <= col_d;
            st_q    <= st_d;
        end
    end

    assign pages     = pages_q;
    assign hpos      = hpos_q;
    assign vpos      = vpos_q;
    assign rowscr_en = row_q;
    assign colscr_en = col_q;
    assign dirty     = dirty_q;
    assign st_dout   = st_q;

endmodule

// File: tb/tb_jts16_scroll_mmr.sv
// tb_jts16_scroll_mmr: directed scoreboard bench for jts16_scroll_mmr.
// Three instances cover MODEL 0, 1 and 2; expectations follow JTS16_SCROLL_LATCH_EN.
module tb_jts16_scroll_mmr;

`ifdef JTS16_SCROLL_LATCH_EN
    localparam bit LATCH = 1'b1;
`else
    localparam bit LATCH = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flip = 1'b0;
    logic        vblank = 1'b0;
    logic        cs0 = 1'b0, cs1 = 1'b0, cs2 = 1'b0;
    logic [11:1] cpu_addr = '0;
    logic [15:0] cpu_dout = '0;
    logic [1:0]  dsn = 2'b11;
    logic [7:0]  st_addr = '0;

    logic [31:0] d0_pages, d0_hpos, d0_vpos;
    logic [1:0]  d0_row, d0_col;
    logic        d0_dirty;
    logic [7:0]  d0_st;
    logic [31:0] d1_pages, d1_hpos, d1_vpos;
    logic [1:0]  d1_row, d1_col;
    logic        d1_dirty;
    logic [7:0]  d1_st;
    logic [63:0] d2_pages, d2_hpos, d2_vpos;
    logic [3:0]  d2_row, d2_col;
    logic        d2_dirty;
    logic [7:0]  d2_st;

    jts16_scroll_mmr #(.LAYERS(2), .MODEL(0)) u_d0 (
        .clk(clk), .rst_n(rst_n), .flip(flip), .vblank(vblank),
        .char_cs(cs0), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .dsn(dsn),
        .pages(d0_pages), .hpos(d0_hpos), .vpos(d0_vpos),
        .rowscr_en(d0_row), .colscr_en(d0_col), .dirty(d0_dirty),
        .st_addr(st_addr), .st_dout(d0_st)
    );

    jts16_scroll_mmr #(.LAYERS(2), .MODEL(1)) u_d1 (
        .clk(clk), .rst_n(rst_n), .flip(flip), .vblank(vblank),
        .char_cs(cs1), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .dsn(dsn),
        .pages(d1_pages), .hpos(d1_hpos), .vpos(d1_vpos),
        .rowscr_en(d1_row), .colscr_en(d1_col), .dirty(d1_dirty),
        .st_addr(st_addr), .st_dout(d1_st)
    );

    jts16_scroll_mmr #(.LAYERS(4), .MODEL(2)) u_d2 (
        .clk(clk), .rst_n(rst_n), .flip(flip), .vblank(vblank),
        .char_cs(cs2), .cpu_addr(cpu_addr), .cpu_dout(cpu_dout), .dsn(dsn),
        .pages(d2_pages), .hpos(d2_hpos), .vpos(d2_vpos),
        .rowscr_en(d2_row), .colscr_en(d2_col), .dirty(d2_dirty),
        .st_addr(st_addr), .st_dout(d2_st)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       tag;
        logic [15:0] exp;
    } sb_t;

    sb_t sbq[$];
    int  checks = 0;
    int  errors = 0;
    int  ncnt = 0;

    task automatic push(input string tag, input logic [15:0] exp);
        sb_t e;
        e.tag = tag;
        e.exp = exp;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [15:0] obs);
        sb_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $error("FAIL sb_underflow observed=%h", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int sel, input logic [8:0] o,
                      input logic [15:0] d, input logic [1:0] ds);
        cs0      = (sel == 0);
        cs1      = (sel == 1);
        cs2      = (sel == 2);
        cpu_addr = {3'b111, o[8:1]};
        cpu_dout = d;
        dsn      = ds;
        tick();
        cs0 = 1'b0;
        cs1 = 1'b0;
        cs2 = 1'b0;
        dsn = 2'b11;
    endtask

    task automatic pulse();
        vblank = 1'b1;
        tick();
        ncnt++;
        vblank = 1'b0;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // reset mid-operation with a pending write
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        wr(2, 9'h0B0, 16'h7777, 2'b00);
        pulse();
        tick();
        wr(2, 9'h0A0, 16'h4321, 2'b00);
        st_addr = 8'hFF;
        rst_n = 1'b0;
        #2;
        ncnt = 0;
        push("rst_hpos", 16'h0000);  chk(d2_hpos[15:0]);
        push("rst_pages", 16'h0000); chk(d2_pages[15:0]);
        push("rst_dirty", 16'h0000); chk({15'b0, d2_dirty});
        push("rst_st", 16'h0000);    chk({8'b0, d2_st});
        rst_n = 1'b1;
        tick();
        push("rst_st_ff", 16'h0000); chk({8'b0, d2_st});
        pulse();
        push("rst_discard", 16'h0000); chk(d2_pages[15:0]);

        // MODEL 2: hpos3 write, vblank held high
        wr(2, 9'h0B6, 16'h1234, 2'b00);
        push("m2_dirty_w", {15'b0, LATCH}); chk({15'b0, d2_dirty});
        tick();
        push("m2_hp3_pre", LATCH ? 16'h0000 : 16'h1234); chk(d2_hpos[63:48]);
        vblank = 1'b1;
        tick();
        ncnt++;
        push("m2_dirty_c", 16'h0000); chk({15'b0, d2_dirty});
        push("m2_hp3_edge", LATCH ? 16'h0000 : 16'h1234); chk(d2_hpos[63:48]);
        tick();
        push("m2_hp3_post", 16'h1234); chk(d2_hpos[63:48]);
        push("m2_row3", 16'h0000);     chk({15'b0, d2_row[3]});
        wr(2, 9'h0B6, 16'h5678, 2'b00);
        push("m2_dirty_hold", {15'b0, LATCH}); chk({15'b0, d2_dirty});
        tick();
        tick();
        push("m2_hp3_hold", LATCH ? 16'h1234 : 16'h5678); chk(d2_hpos[63:48]);
        vblank = 1'b0;
        tick();
        pulse();
        push("m2_hp3_new", 16'h5678); chk(d2_hpos[63:48]);
        st_addr = 8'd22;
        tick();
        push("m2_st22", 16'h0078); chk({8'b0, d2_st});
        st_addr = 8'd23;
        tick();
        push("m2_st23", 16'h0056); chk({8'b0, d2_st});
        st_addr = 8'hFF;
        tick();
        push("m2_st_ff", {8'b0, 1'b0, 7'(ncnt)}); chk({8'b0, d2_st});

        // byte lanes and column-scroll enable
        wr(2, 9'h0B0, 16'hAAAA, 2'b00);
        wr(2, 9'h0B0, 16'h5566, 2'b01);
        wr(2, 9'h0AC, 16'h8000, 2'b00);
        pulse();
        push("lane_hi", 16'h55AA);  chk(d2_hpos[15:0]);
        push("vpos2", 16'h8000);    chk(d2_vpos[47:32]);
        push("col_en", 16'h0004);   chk({12'b0, d2_col});
        push("row_en", 16'h0000);   chk({12'b0, d2_row});
        wr(2, 9'h0B0, 16'h1199, 2'b10);
        pulse();
        push("lane_lo", 16'h5599);  chk(d2_hpos[15:0]);
        wr(2, 9'h0B8, 16'hFFFF, 2'b00);
        push("unmapped_dirty", 16'h0000); chk({15'b0, d2_dirty});
        wr(2, 9'h0B0, 16'h1111, 2'b11);
        push("nostrobe_dirty", 16'h0000); chk({15'b0, d2_dirty});
        pulse();
        push("nostrobe_hp0", 16'h5599); chk(d2_hpos[15:0]);
        push("unmapped_hp3", 16'h5678); chk(d2_hpos[63:48]);

        // MODEL 0: flip page pairs
        flip = 1'b0;
        wr(0, 9'h08E, 16'h0102, 2'b00);
        wr(0, 9'h09E, 16'h0304, 2'b00);
        wr(0, 9'h08C, 16'h0A0B, 2'b00);
        wr(0, 9'h1F8, 16'h8000, 2'b00);
        pulse();
        push("m0_nofl", 16'h0304);  chk(d0_pages[15:0]);
        push("m0_hpos0", 16'h8000); chk(d0_hpos[15:0]);
        push("m0_row", 16'h0000);   chk({14'b0, d0_row});
        flip = 1'b1;
        tick();
        push("m0_flip0", 16'h0102); chk(d0_pages[15:0]);
        push("m0_flip1", 16'h0A0B); chk(d0_pages[31:16]);
        flip = 1'b0;
        st_addr = 8'd0;
        tick();
        push("m0_unflip1", 16'h0000); chk(d0_pages[31:16]);
        push("m0_st0", 16'h0004);     chk({8'b0, d0_st});
        st_addr = 8'd1;
        tick();
        push("m0_st1", 16'h0003);     chk({8'b0, d0_st});

        // MODEL 1: write on the commit edge, alt set on status port
        vblank = 1'b1;
        wr(1, 9'h098, 16'h8001, 2'b00);
        ncnt++;
        push("m1_dirty_edge", 16'h0000); chk({15'b0, d1_dirty});
        tick();
        push("m1_hpos0", 16'h8001); chk(d1_hpos[15:0]);
        push("m1_row0", 16'h0001);  chk({15'b0, d1_row[0]});
        vblank = 1'b0;
        st_addr = 8'hFF;
        tick();
        push("m1_st_ff", {8'b0, 1'b0, 7'(ncnt)}); chk({8'b0, d1_st});
        wr(1, 9'h09C, 16'hBEEF, 2'b00);
        wr(1, 9'h084, 16'h00C3, 2'b00);
        pulse();
        push("m1_hpos_keep", 16'h8001); chk(d1_hpos[15:0]);
        push("m1_pages_keep", 16'h0000); chk(d1_pages[15:0]);
        st_addr = 8'h44;
        tick();
        push("m1_alt_h_lo", 16'h00EF); chk({8'b0, d1_st});
        push("m2_alt_zero", 16'h0000); chk({8'b0, d2_st});
        st_addr = 8'h45;
        tick();
        push("m1_alt_h_hi", 16'h00BE); chk({8'b0, d1_st});
        st_addr = 8'h40;
        tick();
        push("m1_alt_pg", 16'h00C3); chk({8'b0, d1_st});
        st_addr = 8'h30;
        tick();
        push("m1_st_other", 16'h0000); chk({8'b0, d1_st});

        // commit counter wrap from reset
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        ncnt = 0;
        tick();
        st_addr = 8'hFF;
        repeat (127) pulse();
        tick();
        push("cnt_127", 16'h007F); chk({8'b0, d2_st});
        pulse();
        tick();
        push("cnt_wrap", 16'h0000); chk({8'b0, d2_st});

        checks++;
        assert (sbq.size() == 0) else begin
            errors++;
            $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/jts16_scroll_mmr.md
# jts16_scroll_mmr

Parametrised, double-buffered scroll register file for the System 16 tilemap layers. It decodes CPU writes in the text-RAM MMR window at 0xE00–0xFFF and holds them in shadow registers. It commits them to the active set at the start of vertical blank, so a frame never sees a half-updated scroll. It feeds page, scroll and row/column-scroll enables to the tilemap renderers and exposes a byte-wide status-dump port.

## Interface
- LAYERS, 2, number of scroll layers (1–4; MODEL 0/1 limited to 2)
- MODEL, 0, address map: 0 = S16A (flip/non-flip page pairs), 1 = S16B (main + alt sets), 2 = linear map
- clk  in  1  system clock
- rst_n  in  1  reset; one clock, reset is asynchronous and active-low
- flip  in  1  screen flip, selects S16A page register
- vblank  in  1  vertical blank, level, synchronous to clk
- char_cs  in  1  text RAM/MMR chip select
- cpu_addr  in  11 ([11:1])  CPU word address
- cpu_dout  in  16  CPU write data
- dsn  in  2  data strobes, active-low, [1] = upper byte
- pages  out  16·LAYERS  active page register per layer, layer k at [16k+15:16k]
- hpos  out  16·LAYERS  active horizontal scroll per layer
- vpos  out  16·LAYERS  active vertical scroll per layer
- rowscr_en  out  LAYERS  row-scroll enable per layer
- colscr_en  out  LAYERS  column-scroll enable per layer
- dirty  out  1  shadow differs from active (write since last commit)
- st_addr  in  8  status dump index
- st_dout  out  8  status dump data

## Operation
- Write strobe: char_cs && cpu_addr[11:9]==3'b111 && dsn!=2'b11. Offset o = {cpu_addr[8:1],1'b0}. Byte merge: upper byte written if !dsn[1], lower if !dsn[0].
- MODEL 0 map: 0x08E/0x09E layer0 pages flip/nofl; 0x08C/0x09C layer1 pages flip/nofl; 0x124/0x126 vpos 0/1; 0x1F8/0x1FA hpos 0/1.
- MODEL 1 map: 0x080/0x082 pages; 0x084/0x086 alt pages; 0x090/0x092 vpos; 0x094/0x096 alt vpos; 0x098/0x09A hpos; 0x09C/0x09E alt hpos. Alt registers are stored and committed; they are visible only on the status port.
- MODEL 2 map: pages 0x0A0+2k, vpos 0x0A8+2k, hpos 0x0B0+2k, for k < LAYERS. Offsets for k ≥ LAYERS are ignored.
- Unmapped offsets: no effect.
- Writes always land in shadow registers and set dirty.
- Commit: on a vblank rising edge, detected against a registered copy of vblank, all shadow registers are copied to active. Dirty clears. The commit counter increments (7 bits, wraps 127→0). The counter increments on every edge, dirty or not.
- Write in the same cycle as the commit edge: the merged new value goes to both shadow and active. Dirty stays 0.
- pages output: MODEL 0 gives flip ? active_flip : active_nofl, registered and re-evaluated every cycle. MODEL 1/2 give active pages directly.
- rowscr_en[k]: active hpos[15] for MODEL 1/2; 0 for MODEL 0.
- colscr_en[k]: active vpos[15] for MODEL 2; 0 otherwise.
- Status port, registered:
  - st_addr = 6k+n, for k < LAYERS, returns active pages lo/hi (n=0,1), vpos lo/hi (n=2,3) and hpos lo/hi (n=4,5). MODEL 0 pages read from nofl.
  - 0x40+6k+n returns the same bytes for the MODEL 1 alt set (0 for other models).
  - 0xFF returns {dirty, commit_cnt[6:0]}.
  - Any other index returns 0.

## Timing
- Reset (asynchronous assert, synchronous release on clk): all shadow/active registers, pages, hpos, vpos, rowscr_en, colscr_en, dirty, commit_cnt, st_dout and the vblank delay register clear to 0.
- Shadow updated on the clock edge ending the write cycle. dirty is high the next cycle.
- Active registers update on the clock edge where vblank=1 and the registered vblank=0. pages/hpos/vpos/enables reflect the change one cycle later (registered outputs).
- flip change reaches pages in MODEL 0 after 1 cycle.
- st_dout latency: 1 cycle from st_addr.
- vblank held high: a single commit only; a new commit needs a low→high transition.
- rst_n asserted mid-frame: pending shadow writes are discarded.

## Configuration
- JTS16_SCROLL_LATCH_EN defined: double-buffered behaviour as above.
- Undefined: shadow and active are merged. Writes reach the active registers directly, and outputs follow one cycle after the write. dirty is tied to 0. commit_cnt still counts vblank edges.

## Test plan
- Reset: rst_n low mid-operation → all outputs 0, st_addr 0xFF reads 0x00.
- MODEL 2, LAYERS 4: write 0x1234 at offset 0x0B6 (hpos3), vblank low → hpos[63:48] stays 0, dirty=1. Vblank rises → hpos3=0x1234 two cycles after the write's next edge, dirty=0, rowscr_en[3]=0.
- Byte lanes: shadow 0xAAAA, write 0x5566 with dsn=2'b01 → after commit the value is 0x55AA.
- MODEL 0: write 0x0102 at 0x08E and 0x0304 at 0x09E, commit. flip=0 → pages[15:0]=0x0304; flip=1 → 0x0102 one cycle later.
- Simultaneous write of 0x8001 to hpos0 (MODEL 1, 0x098) on the vblank edge → hpos0=0x8001, rowscr_en[0]=1, dirty=0, commit_cnt increments by 1.
- Counter wrap: 128 vblank pulses → st_addr 0xFF reads 0x00 (dirty 0). Macro undefined: a write appears on the output the next cycle with vblank low, and dirty stays 0.
